// File: rtl/scratchpad_arbiter.sv
// rtl/scratchpad_arbiter.sv - round-robin arbiter sharing a single-port 64-bit scratchpad RAM
// A locked requester keeps the port until it releases or LOCK_MAX cycles have elapsed.
module scratchpad_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter logic [31:0] ADDRESS  = 32'h0,
  parameter logic [31:0] DEPTH    = 32'h100,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_write_i,
  input  logic [NUM_REQ-1:0]         req_lock_i,
  input  logic [NUM_REQ*AW-1:0]      req_addr_i,
  input  logic [NUM_REQ*DW-1:0]      req_wdata_i,
  input  logic [NUM_REQ*DW/8-1:0]    req_mask_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [DW-1:0]              rsp_rdata_o,
  output logic                       rsp_error_o,
  output logic                       ram_req_o,
  output logic                       ram_write_o,
  output logic [$clog2(DEPTH/8)-1:0] ram_addr_o,
  output logic [DW-1:0]              ram_wdata_o,
  output logic [DW-1:0]              ram_wmask_o,
  input  logic [DW-1:0]              ram_rdata_i
);

  localparam int unsigned WORDS = DEPTH / 8;
  localparam int unsigned RAW   = $clog2(WORDS);
  localparam int unsigned IW    = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(LOCK_MAX) + 1;
  localparam int unsigned MW    = DW / 8;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;

  logic               grant_vld;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      cand;
  logic               accept;
  logic [NUM_REQ-1:0] grant_oh;
  logic [AW-1:0]      sel_addr, offset, word;
  logic [MW-1:0]      sel_mask;
  logic               sel_err;

  // Descending scan so the last hit is the requester nearest after rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      grant_vld = req_valid_i[owner_q];
      winner    = owner_q;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = IW'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ));
        if (req_valid_i[cand]) begin
          grant_vld = 1'b1;
          winner    = cand;
        end
      end
    end
  end

  assign accept      = grant_vld & rst_ni;
  assign grant_oh    = accept ? (NUM_REQ'(1) << winner) : '0;
  assign req_ready_o = grant_oh;

  // Addresses below the base wrap to huge word indices and fail the range check.
  assign sel_addr = req_addr_i[winner*AW +: AW];
  assign offset   = sel_addr - AW'(ADDRESS);
  assign word     = offset >> 3;
  assign sel_err  = (word >= AW'(WORDS)) || (sel_addr < AW'(ADDRESS));
  assign sel_mask = req_mask_i[winner*MW +: MW];

  assign ram_req_o   = accept;
  assign ram_write_o = accept & req_write_i[winner] & ~sel_err;
  assign ram_addr_o  = word[RAW-1:0];
  assign ram_wdata_o = req_wdata_i[winner*DW +: DW];

  always_comb begin
    ram_wmask_o = '0;
    for (int b = 0; b < MW; b++) begin
      ram_wmask_o[b*8 +: 8] = {8{sel_mask[b]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    rsp_valid_d = grant_oh;
    rsp_error_d = accept & sel_err;
    if (accept) begin
      rr_ptr_d = winner;
    end
    case (state_q)
      IDLE: begin
        if (accept && req_lock_i[winner]) begin
          state_d    = LOCKED;
          owner_d    = winner;
          lock_cnt_d = '0;
        end
      end
      LOCKED: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if ((accept && !req_lock_i[winner]) || (lock_cnt_d >= CW'(LOCK_MAX - 1))) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// tb/tb_scratchpad_arbiter.sv - directed and random checks of scratchpad_arbiter against a cycle-level model
module tb_scratchpad_arbiter;

  localparam int          N     = 3;
  localparam int          AW    = 32;
  localparam int          DW    = 64;
  localparam int          LM    = 4;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam logic [31:0] DEPTH = 32'h100;
  localparam int          WORDS = DEPTH / 8;
  localparam int          RAW   = $clog2(WORDS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      valid, write, lock;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N*DW/8-1:0] mask;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata, ram_wdata, ram_wmask, ram_rdata;
  logic              rsp_error, ram_req, ram_write;
  logic [RAW-1:0]    ram_addr;

  scratchpad_arbiter #(
    .NUM_REQ(N), .ADDRESS(BASE), .DEPTH(DEPTH), .AW(AW), .DW(DW), .LOCK_MAX(LM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(req_ready), .req_write_i(write), .req_lock_i(lock),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_mask_i(mask),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
  );

  // Scratchpad RAM with a registered read port.
  logic [DW-1:0] ram_mem [WORDS];
  logic [DW-1:0] ram_rd;
  always @(posedge clk) begin
    if (ram_req) begin
      ram_rd <= ram_mem[ram_addr];
      if (ram_write) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end
  assign ram_rdata = ram_rd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] model_mem [WORDS];
  int            rr = N - 1;
  bit            locked = 0;
  int            owner = 0;
  int            free_at = 0;
  int            cyc = 0;
  logic [N-1:0]  exp_rv = '0;
  bit            exp_err = 0;
  bit            exp_rd_chk = 0;
  logic [DW-1:0] exp_rdata = '0;
  int            glog[$];
  logic [DW-1:0] last_rdata;

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    valid[i] = v; write[i] = w; lock[i] = l;
    addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; mask[i*8 +: 8] = m;
  endtask

  task automatic clear_reqs();
    valid = '0; write = '0; lock = '0; addr = '0; wdata = '0; mask = '0;
  endtask

  // One clock: check last cycle's response, check this cycle's grant/RAM drive, advance model.
  task automatic step();
    int win, obs, wd;
    bit was_locked, err;
    logic [31:0] a;
    logic [DW-1:0] bm;
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, exp_rv);
    last_rdata = rsp_rdata;
    if (exp_rv != '0) begin
      check_eq("rsp_error", rsp_error, exp_err);
      if (exp_rd_chk) check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    end
    obs = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs = i;
    glog.push_back(obs);

    win = -1;
    was_locked = locked && (cyc < free_at);
    if (!was_locked) locked = 0;
    if (was_locked) begin
      if (valid[owner]) win = owner;
    end else begin
      for (int k = N; k >= 1; k--) if (valid[(rr + k) % N]) win = (rr + k) % N;
    end

    check_eq("ready", req_ready, (win >= 0) ? (N'(1) << win) : '0);
    check_eq("ram_req", ram_req, win >= 0);
    exp_rv = '0;
    if (win >= 0) begin
      a   = addr[win*AW +: AW];
      err = (a < BASE) || (a >= BASE + DEPTH);
      wd  = err ? 0 : int'((a - BASE) / 8);
      check_eq("ram_write", ram_write, write[win] && !err);
      if (!err) check_eq("ram_addr", ram_addr, wd);
      if (write[win] && !err) begin
        for (int b = 0; b < 8; b++) bm[b*8 +: 8] = mask[win*8 + b] ? 8'hFF : 8'h00;
        check_eq("ram_wmask", ram_wmask, bm);
        check_eq("ram_wdata", ram_wdata, wdata[win*DW +: DW]);
        model_mem[wd] = (model_mem[wd] & ~bm) | (wdata[win*DW +: DW] & bm);
      end
      exp_rv     = N'(1) << win;
      exp_err    = err;
      exp_rd_chk = !write[win] && !err;
      exp_rdata  = model_mem[wd];
      rr = win;
      if (!was_locked && lock[win]) begin
        locked = 1; owner = win; free_at = cyc + LM;
      end else if (was_locked && !lock[win]) begin
        locked = 0;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_ram_req", ram_req, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, '0);
    check_eq("rst_rsp_error", rsp_error, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr = N - 1; locked = 0; exp_rv = '0; cyc++;
  endtask

  initial begin
    int exp_c[4] = '{0, 1, 0, 1};
    int exp_l[4] = '{1, 1, 1, 0};
    int exp_t[5] = '{0, 0, 0, 0, 1};
    logic [31:0] ra;
    for (int w = 0; w < WORDS; w++) begin
      ram_mem[w]   = {$urandom, $urandom};
      model_mem[w] = ram_mem[w];
    end
    ram_mem[2]   = 64'hDEADBEEF_CAFEF00D;
    model_mem[2] = 64'hDEADBEEF_CAFEF00D;
    clear_reqs();
    valid = '1;
    #1;
    do_reset();
    clear_reqs();

    // Contention from reset
    glog.delete();
    set_req(0, 1, 0, 0, BASE + 32'h8, '0, 8'h00);
    set_req(1, 1, 0, 0, BASE + 32'h18, '0, 8'h00);
    repeat (4) step();
    for (int k = 0; k < 4; k++) check_eq("contend_grant", glog[k], exp_c[k]);
    clear_reqs();
    step();

    // Single read of preloaded word 2
    set_req(0, 1, 0, 0, BASE + 32'h10, '0, 8'h00);
    step();
    clear_reqs();
    step();
    check_eq("single_rdata", last_rdata, 64'hDEADBEEF_CAFEF00D);

    // Locked burst by requester 1 while requester 0 waits
    glog.delete();
    set_req(0, 1, 0, 0, BASE, '0, 8'h00);
    set_req(1, 1, 1, 1, BASE + 32'h20, 64'h1111_2222_3333_4444, 8'hFF);
    step();
    set_req(1, 1, 1, 1, BASE + 32'h28, 64'h5555_6666_7777_8888, 8'h0F);
    step();
    set_req(1, 1, 1, 0, BASE + 32'h30, 64'h9999_AAAA_BBBB_CCCC, 8'hF0);
    step();
    valid[1] = 1'b0;
    step();
    for (int k = 0; k < 4; k++) check_eq("burst_grant", glog[k], exp_l[k]);
    clear_reqs();
    step();

    // Lock timeout
    glog.delete();
    set_req(0, 1, 0, 1, BASE + 32'h40, '0, 8'h00);
    step();
    set_req(1, 1, 0, 0, BASE + 32'h48, '0, 8'h00);
    repeat (4) step();
    for (int k = 0; k < 5; k++) check_eq("timeout_grant", glog[k], exp_t[k]);
    clear_reqs();
    repeat (2) step();

    // Out-of-range accesses
    set_req(0, 1, 1, 0, BASE + DEPTH, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    step();
    set_req(0, 1, 0, 0, BASE - 32'h8, '0, 8'h00);
    step();
    clear_reqs();
    step();

    // Reset in the middle of a locked burst
    set_req(2, 1, 1, 1, BASE + 32'h50, 64'h0123_4567_89AB_CDEF, 8'h3C);
    step();
    step();
    do_reset();
    clear_reqs();
    glog.delete();
    set_req(0, 1, 0, 0, BASE + 32'h58, '0, 8'h00);
    set_req(1, 1, 0, 0, BASE + 32'h60, '0, 8'h00);
    step();
    check_eq("post_reset_grant", glog[0], 0);
    clear_reqs();
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom % 10)
          0:       ra = BASE - 32'(8 * $urandom_range(1, 4)) + 32'($urandom_range(0, 7));
          1:       ra = BASE + DEPTH + 32'($urandom_range(0, 31));
          default: ra = BASE + 32'($urandom_range(0, int'(DEPTH) - 1));
        endcase
        set_req(i, ($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
                ra, {$urandom, $urandom}, 8'($urandom));
      end
      step();
    end
    clear_reqs();
    step();

    for (int w = 0; w < WORDS; w++) check_eq("ram_contents", ram_mem[w], model_mem[w]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
